// File: rtl/robs_pkg.sv
// Shared types and constants for the Robertson multiplier control path.
package robs_pkg;

  localparam int CW = 15;

  // Sequencer states; one full multiplication walks INIT..DONE once.
  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    INIT  = 4'd1,
    LOADR = 4'd2,
    COUNT = 4'd3,
    TEST  = 4'd4,
    ADD   = 4'd5,
    SUB   = 4'd6,
    SHIFT = 4'd7,
    WB    = 4'd8,
    STORE = 4'd9,
    DONE  = 4'd10
  } state_t;

  // Control word bit positions.
  localparam int C_LOAD_Y      = 0;
  localparam int C_CNT_RST     = 1;
  localparam int C_CLR_A       = 2;
  localparam int C_LOAD_X      = 3;
  localparam int C_RH_SEL_LO   = 4;
  localparam int C_RH_SEL_HI   = 5;
  localparam int C_RL_SEL      = 6;
  localparam int C_X_SEL       = 7;
  localparam int C_LOAD_RH     = 8;
  localparam int C_LOAD_RL     = 9;
  localparam int C_ADDSUB      = 10;
  localparam int C_SHIFT_ARITH = 11;
  localparam int C_SHIFT_EN    = 12;
  localparam int C_CNT_DEC     = 13;
  localparam int C_LOAD_A      = 14;

  // rh mux select encodings.
  localparam logic [1:0] RH_A   = 2'd0;
  localparam logic [1:0] RH_SR  = 2'd1;
  localparam logic [1:0] RH_ALU = 2'd2;

  localparam logic ADDSUB_ADD = 1'b1;

endpackage

// File: rtl/robs_ctrl_decode.sv
// Combinational decode of the sequencer state into the datapath control word.
module robs_ctrl_decode
  import robs_pkg::*;
(
  input  state_t          state_i,
  output logic [CW-1:0]   c_o
);

  // Every bit defaults to 0; each state raises only the controls it needs.
  always_comb begin
    c_o = '0;
    case (state_i)
      INIT: begin
        c_o[C_LOAD_Y]  = 1'b1;
        c_o[C_CNT_RST] = 1'b1;
        c_o[C_CLR_A]   = 1'b1;
        c_o[C_LOAD_X]  = 1'b1;
        c_o[C_X_SEL]   = 1'b0;  // x takes the multiplier operand
      end
      LOADR: begin
        // rh <- a (just cleared), rl <- x: r = {0, multiplier}
        c_o[C_LOAD_RH] = 1'b1;
        c_o[C_LOAD_RL] = 1'b1;
      end
      COUNT: c_o[C_CNT_DEC] = 1'b1;
      ADD: begin
        c_o[C_RH_SEL_HI:C_RH_SEL_LO] = RH_ALU;
        c_o[C_LOAD_RH]               = 1'b1;
        c_o[C_ADDSUB]                = ADDSUB_ADD;
      end
      SUB: begin
        // Last iteration subtracts: the multiplier's sign bit has negative weight.
        c_o[C_RH_SEL_HI:C_RH_SEL_LO] = RH_ALU;
        c_o[C_LOAD_RH]               = 1'b1;
        c_o[C_ADDSUB]                = ~ADDSUB_ADD;
      end
      SHIFT: begin
        c_o[C_SHIFT_EN]    = 1'b1;
        c_o[C_SHIFT_ARITH] = 1'b1;
      end
      WB: begin
        c_o[C_RH_SEL_HI:C_RH_SEL_LO] = RH_SR;
        c_o[C_RL_SEL]                = 1'b1;
        c_o[C_LOAD_RH]               = 1'b1;
        c_o[C_LOAD_RL]               = 1'b1;
      end
      STORE: begin
        c_o[C_LOAD_A] = 1'b1;
        c_o[C_LOAD_X] = 1'b1;
        c_o[C_X_SEL]  = 1'b1;   // x takes the low half of r
      end
      default: c_o = '0;
    endcase
  end

endmodule

// File: rtl/robs_control_unit.sv
// Moore sequencer driving the Robertson datapath through one signed multiply.
module robs_control_unit
  import robs_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW_P  = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            zr,
  input  logic            zq,
  output logic [CW-1:0]   c,
  output logic            busy,
  output logic            done
);

  // zq is a mod-8 test on the counter, so only 8-bit operands make sense.
  if (WIDTH != 8) begin : g_bad_width
    $error("robs_control_unit: WIDTH must be 8");
  end
  if (CW_P != CW) begin : g_bad_cw
    $error("robs_control_unit: control word width must be 15");
  end

  state_t state_q, state_d;

  // State register with synchronous reset back to IDLE.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; unknown encodings fall back to IDLE.
  always_comb begin
    state_d = IDLE;
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    case (state_q)
      IDLE:  state_d = start ? INIT : IDLE;
      INIT:  state_d = LOADR;
      LOADR: state_d = COUNT;
      COUNT: state_d = TEST;
      TEST: begin
        if (zr)      state_d = SHIFT;
        else if (zq) state_d = SUB;
        else         state_d = ADD;
      end
      ADD:   state_d = SHIFT;
      SUB:   state_d = SHIFT;
      SHIFT: state_d = WB;
      // Counter is untouched between TEST and WB, so zq still marks the 8th pass.
      WB:    state_d = zq ? STORE : COUNT;
      STORE: state_d = DONE;
      DONE:  state_d = IDLE;
      default: begin
        state_d = IDLE;
        busy    = 1'b0;
        done    = 1'b0;
      end
    endcase
  end

  robs_ctrl_decode u_decode (
    .state_i (state_q),
    .c_o     (c)
  );

endmodule
